// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 mouse receiver:
//   - receive FSM state encoding
//   - bit positions of the fields on the 25-bit ps2_mouse packet bus
//   - position of the always-one sync bit in the status byte
//   - odd-parity helper, used by the optional parity check
// ----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Packet bus layout: {strobe, Y, X, status}
   localparam int PKT_STATUS_LSB = 0;
   localparam int PKT_X_LSB      = 8;
   localparam int PKT_Y_LSB      = 16;
   localparam int PKT_STROBE_BIT = 24;
   localparam int PKT_W          = 25;

   // Bit 3 of the first byte of every mouse packet is always 1.
   localparam int SYNC_BIT = 3;

   // True when the 8 data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ----------------------------------------------------------------------------
// ps2_clk_filter
// Brings one raw PS/2 line into the clk domain: 2-flop synchronizer, then a
// glitch filter that only changes its output after FILTER_LEN consecutive
// samples at the new level. Optionally produces a one-cycle falling-edge pulse.
//
// Parameters:
//   FILTER_LEN - consecutive stable samples needed to change the output level
//   EDGE_EN    - 1: fall pulses on filtered 1->0 transitions; 0: fall tied low
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset (output presets to idle-high)
//   line    - raw PS/2 line, asynchronous to clk
//   level   - filtered line level
//   fall    - one-cycle pulse, the cycle after level drops from 1 to 0
// ----------------------------------------------------------------------------
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8,
   parameter bit EDGE_EN    = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic line,
   output logic level,
   output logic fall
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             fall_q;

   // NOTE: all sequential state is updated with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbours, regardless of
   // statement order inside the block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], line};
         fall_q <= 1'b0;
         // Count samples that disagree with the current output; any sample
         // that agrees restarts the count, so short glitches never get through.
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
            fall_q  <= level_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level = level_q;
   assign fall  = EDGE_EN ? fall_q : 1'b0;

endmodule

// File: rtl/ps2_mouse_rx.sv
// ----------------------------------------------------------------------------
// ps2_mouse_rx
// Receives 11-bit PS/2 frames (start, 8 data LSB first, parity, stop) from a
// mouse, assembles 3-byte movement packets and presents them on a packet bus
// with a one-cycle new-packet strobe. A frame with a bad stop bit, or a stalled
// transfer (no PS/2 clock falling edge for TIMEOUT_CYC cycles), abandons the
// packet in progress and pulses frame_err.
//
// Build option:
//   PS2_MOUSE_PARITY_CHK_EN - when defined, frames whose data+parity bits do
//                             not have odd parity are rejected like a bad stop.
// Parameters:
//   FILTER_LEN  - glitch filter length on both PS/2 lines (clk samples)
//   TIMEOUT_CYC - clk cycles without a PS/2 clock falling edge before abort
// Ports:
//   clk        - system clock, the only clock domain
//   reset_n    - asynchronous active-low reset
//   ps2_clk_i  - raw PS/2 clock line
//   ps2_data_i - raw PS/2 data line
//   ps2_mouse  - [7:0] status, [15:8] X, [23:16] Y, [24] new-packet strobe
//   frame_err  - one-cycle pulse on a rejected frame or a timeout
// ----------------------------------------------------------------------------
module ps2_mouse_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 42000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   output logic [24:0] ps2_mouse,
   output logic        frame_err
);

   import ps2_pkg::*;

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   // -------------------------------------------------------------------------
   // Line conditioning
   // -------------------------------------------------------------------------
   logic clk_level_unused;
   logic clk_fall;
   logic data_lvl;
   logic data_fall_unused;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN), .EDGE_EN(1'b1)) u_clk_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .line    (ps2_clk_i),
      .level   (clk_level_unused),
      .fall    (clk_fall)
   );

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN), .EDGE_EN(1'b0)) u_data_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .line    (ps2_data_i),
      .level   (data_lvl),
      .fall    (data_fall_unused)
   );

   // -------------------------------------------------------------------------
   // Receiver state
   // -------------------------------------------------------------------------
   ps2_state_e        state_q;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic              parity_q;
   logic [1:0]        idx_q;
   logic [7:0]        byte0_q;
   logic [7:0]        byte1_q;
   logic [7:0]        byte2_q;
   logic              done_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [PKT_W-1:0]  pkt_q;
   logic              frame_err_q;

   logic frame_ok;
   logic busy;
   logic timeout;

`ifdef PS2_MOUSE_PARITY_CHK_EN
   assign frame_ok = data_lvl & odd_parity_ok(shift_q, parity_q);
`else
   // Parity is still clocked in, but its value plays no part in acceptance.
   logic parity_unused;
   assign parity_unused = parity_q;
   assign frame_ok      = data_lvl;
`endif

   // The bus is quiet only when idle between packets; a stall anywhere else
   // (mid-frame or between bytes of a packet) must eventually abort.
   assign busy    = (state_q != ST_IDLE) || (idx_q != 2'd0);
   assign timeout = busy && (to_cnt_q == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         idx_q       <= '0;
         byte0_q     <= '0;
         byte1_q     <= '0;
         byte2_q     <= '0;
         done_q      <= 1'b0;
         to_cnt_q    <= '0;
         pkt_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         done_q      <= 1'b0;

         // Output register: all three bytes land together with the strobe;
         // otherwise only the strobe drops and the data holds.
         if (done_q) begin
            pkt_q <= {1'b1, byte2_q, byte1_q, byte0_q};
         end else begin
            pkt_q[PKT_STROBE_BIT] <= 1'b0;
         end

         // Timeout has priority over a coincident edge: the edge is dropped.
         if (timeout) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b1;
         end else if (clk_fall) begin
            to_cnt_q <= '0;
            unique case (state_q)
               ST_IDLE: begin
                  if (!data_lvl) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  shift_q   <= {data_lvl, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  parity_q <= data_lvl;
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  if (!frame_ok) begin
                     idx_q       <= '0;
                     frame_err_q <= 1'b1;
                  end else begin
                     unique case (idx_q)
                        2'd0: begin
                           // Without the sync bit this cannot be a status
                           // byte; drop it and keep hunting for alignment.
                           if (shift_q[SYNC_BIT]) begin
                              byte0_q <= shift_q;
                              idx_q   <= 2'd1;
                           end
                        end
                        2'd1: begin
                           byte1_q <= shift_q;
                           idx_q   <= 2'd2;
                        end
                        2'd2: begin
                           byte2_q <= shift_q;
                           done_q  <= 1'b1;
                           idx_q   <= 2'd0;
                        end
                        default: idx_q <= 2'd0;
                     endcase
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (busy) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   assign ps2_mouse = pkt_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_mouse_rx.md
PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive stable clk samples needed before the filtered PS/2 clock changes level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 42000: clk cycles without a filtered PS/2 clock falling edge before an abort (about 2 ms at 21.48 MHz).
REQ-003 SHALL have clk, input, 1, the single system clock; all state is in this domain.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ps2_clk_i, input, 1, raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have ps2_data_i, input, 1, raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have ps2_mouse, output, 25, packet bus:
- [7:0] status byte.
- [15:8] X byte.
- [23:16] Y byte.
- [24] new-packet strobe.
REQ-008 SHALL have frame_err, output, 1, one-cycle pulse on a rejected frame or a timeout.

Function
REQ-009 SHALL pass each raw line through a 2-flop synchronizer and then the FILTER_LEN glitch filter before use.
REQ-010 SHALL sample data only on a falling edge of the filtered ps2_clk.
REQ-011 SHALL receive frames with an FSM IDLE -> DATA -> PARITY -> STOP -> IDLE.
REQ-012 SHALL, in IDLE, start a frame only on a falling edge with data=0; data=1 is ignored and the FSM stays in IDLE.
REQ-013 SHALL, in DATA, shift in 8 bits LSB first using a 3-bit counter, and move to PARITY after bit 7.
REQ-014 SHALL, in PARITY, latch the parity bit and move to STOP.
REQ-015 SHALL, in STOP, accept the byte if data=1; if data=0, discard the byte, pulse frame_err and clear the byte index.
REQ-016 SHALL keep a byte index 0..2 for the packet in progress.
REQ-017 SHALL accept a byte at index 0 only if bit3=1 (sync bit); otherwise discard it and leave the index at 0.
REQ-018 SHALL, once the byte at index 2 is accepted, load [7:0], [15:8] and [23:16] together and set [24]=1 on the next cycle.
REQ-019 SHALL hold [24] high for exactly one clk cycle per packet; [23:0] SHALL hold until the next packet completes.
REQ-020 SHALL, when the timeout counter reaches TIMEOUT_CYC in any state other than IDLE with index 0:
- return to IDLE;
- clear the index;
- pulse frame_err.
REQ-021 SHALL clear the timeout counter on every filtered falling edge.
REQ-022 SHALL copy overflow and sign bits through unchanged, with no arithmetic on X or Y.
REQ-023 SHALL let a timeout on the same cycle as a falling edge win: abort, and ignore the edge.
REQ-024 SHALL have a latency from the STOP-bit falling edge to [24]=1 of exactly 2 clk cycles.

Reset
REQ-025 SHALL, when reset_n=0, immediately set:
- FSM to IDLE;
- index, shift register and timeout counter to 0;
- ps2_mouse to 0 and frame_err to 0.
REQ-026 SHALL preset the filter outputs to 1 (idle bus) on reset.
REQ-027 SHALL treat a reset mid-frame as abandoning the packet; after release, reception resumes at the next start bit with index 0.

Configuration
REQ-028 SHALL, with PS2_MOUSE_PARITY_CHK_EN defined, reject a frame unless the 8 data bits plus parity have odd total parity; a rejected frame is handled as in REQ-015.
REQ-029 SHALL, without PS2_MOUSE_PARITY_CHK_EN, ignore the parity bit value, while still clocking it in through the PARITY state.

Structure
REQ-030 SHALL place in shared package ps2_pkg:
- the FSM state enum;
- the packet field bit-position constants;
- the sync-bit position constant (3).
REQ-031 SHALL implement the synchronizer, glitch filter and falling-edge detect as sub-module ps2_clk_filter, instantiated once per line; falling-edge detect is used on the clock instance only.

Verification
REQ-032 SHALL cover a valid packet: bytes 0x09, 0x10, 0xF0 with correct parity at 12.5 kHz -> ps2_mouse[23:0]=0xF01009 and exactly one [24] pulse, 2 cycles after the third stop edge.
REQ-033 SHALL cover sync loss: bytes 0x05, 0x08, 0x20, 0x30 -> 0x05 discarded, then packet 0x302008, with no frame_err.
REQ-034 SHALL cover a bad stop bit: second byte sent with stop=0 -> one frame_err pulse, no [24]; the following 3-byte packet is received correctly.
REQ-035 SHALL cover a parity error: byte 0x08 with even parity -> with PS2_MOUSE_PARITY_CHK_EN, frame_err and no packet; without it, the packet completes.
REQ-036 SHALL cover a timeout: stop after 1.5 bytes and wait TIMEOUT_CYC+1 cycles -> one frame_err; the next full packet decodes correctly.
REQ-037 SHALL cover glitch and reset:
- a 3-cycle low glitch on ps2_clk_i produces no sampled bit;
- reset_n low mid-byte clears ps2_mouse to 0 immediately.
